instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'd0, meaning the first fetch address after reset.
REQ-002 The module SHALL have parameter HALT_ADDR, default 32'd80, meaning the byte address at which fetching stops.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The module SHALL have port imem_addr, output, 32 bits, the byte address driven to instructionmemory src.
REQ-006 The module SHALL have port imem_data, input, 32 bits, the big-endian word returned combinationally by instructionmemory.
REQ-007 The module SHALL have port instr, output, 32 bits, the registered instruction presented to decode.
REQ-008 The module SHALL have port instr_pc, output, 32 bits, the address instr was fetched from.
REQ-009 The module SHALL have port instr_valid, output, 1 bit, meaning instr/instr_pc hold an unconsumed instruction.
REQ-010 The module SHALL have port instr_ready, input, 1 bit, meaning decode accepts instr this cycle.
REQ-011 The module SHALL have port redirect_valid, input, 1 bit, meaning a taken branch from execute.
REQ-012 The module SHALL have port redirect_target, input, 32 bits, the absolute branch target byte address.
REQ-013 The module SHALL have port halted, output, 1 bit, high while in state HALT.
REQ-014 The module SHALL have port misalign, output, 1 bit, a sticky flag set by a redirect whose target[1:0] is nonzero.

Function
REQ-015 imem_addr SHALL equal the internal PC register combinationally; no extra latency.
REQ-016 FSM states SHALL be RUN and HALT; reset enters RUN.
REQ-017 A transfer SHALL occur when instr_valid && instr_ready; a capture slot SHALL exist when !instr_valid || instr_ready.
REQ-018 In RUN with a capture slot, no redirect, and PC != HALT_ADDR, the module SHALL load instr<=imem_data, instr_pc<=PC, instr_valid<=1, and PC<=PC+4 (modulo 2^32, wrapping 0xFFFFFFFC to 0).
REQ-019 While instr_valid && !instr_ready, instr, instr_pc, instr_valid and PC SHALL hold unchanged.
REQ-020 In RUN, redirect_valid SHALL take priority over capture: PC<={redirect_target[31:2],2'b00} and instr_valid<=0 on the next edge, regardless of instr_ready.
REQ-021 A redirect with redirect_target[1:0]!=0 SHALL set misalign to 1; misalign SHALL clear only on reset.
REQ-022 In RUN, when PC==HALT_ADDR and no redirect, the FSM SHALL move to HALT, with no capture that cycle.
REQ-023 In HALT, PC SHALL hold, no capture SHALL occur, redirect_valid SHALL be ignored, and any held instruction SHALL remain valid until transferred, then instr_valid<=0.
REQ-024 HALT SHALL be left only by reset.

Reset
REQ-025 Asserting rst_n low SHALL immediately force PC=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0, misalign=0 and state RUN, including mid-stall or mid-redirect.
REQ-026 The first capture SHALL occur on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro FETCH_PERF_EN, when defined, SHALL add outputs fetch_count (32 bits, +1 per capture) and redirect_count (32 bits, +1 per accepted redirect in RUN), both reset to 0 and wrapping.
REQ-028 Without FETCH_PERF_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 Shared package fetch_pkg SHALL hold ADDR_W=32, INSTR_W=32, PC_STEP=4, and the fetch_state_t enum {RUN, HALT}.
REQ-030 The valid/ready output register SHALL be sub-module fetch_out_reg; PC and FSM logic SHALL live in instr_fetch_unit.

Verification
REQ-031 Reset then instr_ready=1 with the GCD program loaded SHALL yield instr_pc 0,4,8 on three consecutive cycles, with instr=0x24010000 at instr_pc=0.
REQ-032 Holding instr_ready=0 for 3 cycles at instr_pc=8 SHALL keep instr=0x30200004 and imem_addr=12 stable, then instr_pc=12 follows one cycle after ready rises.
REQ-033 redirect_valid=1, target=0x20, with instr_ready=0 SHALL give instr_valid=0 next cycle and instr_pc=0x20 the cycle after.
REQ-034 A redirect to 0x22 SHALL fetch from 0x20 and set misalign=1, and misalign SHALL stay 1 until rst_n is pulsed.
REQ-035 Sequential run to PC=80 SHALL assert halted, SHALL not present instr_pc=80, and a subsequent redirect to 0 SHALL be ignored.
REQ-036 rst_n low mid-stall at instr_pc=44 SHALL force instr_valid=0 and imem_addr=0 before the next clock edge; with FETCH_PERF_EN, fetch_count SHALL read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, PC increment and FSM state type for the instruction fetch slice.
package fetch_pkg;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output register holding the instruction presented to decode.
// flush beats load; a transfer with no refill drops instr_valid.
module fetch_out_reg
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               slot
);
  assign slot = !instr_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (flush) begin
      instr_valid <= 1'b0;
    end else if (load) begin
      instr       <= load_instr;
      instr_pc    <= load_pc;
      instr_valid <= 1'b1;
    end else if (instr_valid && out_ready) begin
      instr_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC register, RUN/HALT FSM, redirect handling.
// Optional FETCH_PERF_EN adds fetch_count / redirect_count outputs.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'd0,
  parameter logic [ADDR_W-1:0] HALT_ADDR = 32'd80
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               halted,
`ifdef FETCH_PERF_EN
  output logic [31:0]        fetch_count,
  output logic [31:0]        redirect_count,
`endif
  output logic               misalign
);
  fetch_state_t      state, state_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic              load, flush, slot, misalign_set;

  assign imem_addr = pc;
  assign halted    = (state == HALT);

  always_comb begin
    state_d      = state;
    pc_d         = pc;
    load         = 1'b0;
    flush        = 1'b0;
    misalign_set = 1'b0;
    case (state)
      RUN: begin
        if (redirect_valid) begin
          pc_d         = {redirect_target[ADDR_W-1:2], 2'b00};
          flush        = 1'b1;
          misalign_set = |redirect_target[1:0];
        end else if (pc == HALT_ADDR) begin
          state_d = HALT;
        end else if (slot) begin
          load = 1'b1;
          pc_d = pc + PC_STEP;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      if (misalign_set) misalign <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (load)  fetch_count    <= fetch_count + 32'd1;
      if (flush) redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

  fetch_out_reg u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .flush      (flush),
    .load_instr (imem_data),
    .load_pc    (pc),
    .out_ready  (instr_ready),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .slot       (slot)
  );
endmodule
